instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, 32'h0, byte address of first written instruction word.
REQ-002 Parameter DEPTH, 256, capacity of the instruction memory in words.
REQ-003 Ports, one per line:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept fields
- cls  in  3  class: 0 lw, 1 sw, 2 R, 3 branch, 4 I-ALU, 5 jal, 6 jalr, 7 lui
- func3  in  3  funct3 for R, I-ALU, branch
- sub  in  1  R-type only: funct7 = 7'b0100000 when 1, else 7'b0
- rd, rs1, rs2  in  5 each  register indices
- imm  in  32  signed immediate (byte offset for branch/jal; full value for lui)
- finish  in  1  level, end of program
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  32  write address
- mem_wdata  out  32  encoded RV32I word
- busy  out  1  state != IDLE and != DONE
- done  out  1  program complete
- err  out  1  sticky: immediate out of range or overflow

Function
REQ-004 States: IDLE, ENC, WRITE, HALT, DONE; in_ready = 1 only in IDLE with count < DEPTH.
REQ-005 Accept on in_valid & in_ready; fields captured into a one-entry buffer; IDLE -> ENC.
REQ-006 ENC registers the encoded word; ENC -> WRITE; WRITE asserts mem_we for exactly one cycle; WRITE -> IDLE.
REQ-007 Latency: accept at edge N, mem_we high during cycle N+2, in_ready high again at N+3.
REQ-008 Encoding: opcodes lw 0000011, sw 0100011, R 0110011, branch 1100011, I-ALU 0010011, jalr 1100111, jal 1101111, lui 0110111.
REQ-009 funct3 forced to 010 for lw/sw and 000 for jalr; otherwise taken from func3; sub ignored except for R.
REQ-010 Immediate fields per RV32I I/S/B/U/J formats; unused register fields written as zero.
REQ-011 Range: lw/sw/jalr/I-ALU -2048..2047; branch -4096..4094 and even; jal +/-1 MiB and even; lui imm[11:0] = 0.
REQ-012 Out-of-range immediate sets err and the word is still written with truncated fields.
REQ-013 mem_addr = BASE_ADDR + 4*count; count increments after each write and never wraps.
REQ-014 count == DEPTH: in_ready = 0; next IDLE cycle moves to DONE with err set.
REQ-015 finish is evaluated only in IDLE with in_valid = 0; in_valid wins when both are high.
REQ-016 DONE: done = 1, in_ready = 0, mem_we = 0; held until rst.

Reset
REQ-017 rst asynchronously forces IDLE, count 0, and mem_we/busy/done/err 0.
REQ-018 rst asynchronously forces mem_addr to BASE_ADDR and mem_wdata to 0.
REQ-019 rst mid-operation, including during WRITE, drops mem_we immediately and discards the buffered word.

Configuration
REQ-020 Macro PROGRAM_HALT_EN defined: finish -> HALT, which writes 32'h00000000 (unrecognized opcode) at the next address with one mem_we cycle, then -> DONE.
REQ-021 PROGRAM_HALT_EN defined with count == DEPTH at finish: no write, err set, -> DONE.
REQ-022 PROGRAM_HALT_EN undefined: finish -> DONE directly with no write; HALT state absent.

Verification
REQ-023 addi x1,x0,5 (cls 4, f3 0, rd 1, imm 5) -> mem_wdata 32'h00500093, addr 0, mem_we two cycles after accept.
REQ-024 sub x3,x1,x2 (cls 2, sub 1, rd 3, rs1 1, rs2 2) next -> 32'h402081B3 at addr 4; sw x2,8(x1) -> 32'h0020A423 at addr 8.
REQ-025 lui x5,0x12345000 -> 32'h123452B7, err 0; beq with imm 4096 -> word written, err 1 and stays 1.
REQ-026 Two words then finish -> PROGRAM_HALT_EN: 32'h0 written at addr 8, then done 1; without: no write, done 1.
REQ-027 DEPTH 2: third in_valid is never accepted, err 1, done 1.
REQ-028 rst during WRITE -> mem_we 0 the same cycle; next accepted word is written at addr 0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder
//   Accepts RV32I instruction fields one at a time, encodes them into 32-bit
//   machine words and writes each word into an instruction memory at
//   consecutive word addresses starting at BASE_ADDR.
//
//   Optional feature macro: PROGRAM_HALT_EN
//     defined   : finish writes a 32'h00000000 terminator word before DONE
//     undefined : finish goes straight to DONE without a write
//
// Parameters
//   BASE_ADDR  byte address of the first written word
//   DEPTH      instruction memory capacity in words
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   in_valid / in_ready    field handshake
//   cls, func3, sub        instruction class, funct3, R-type subtract select
//   rd, rs1, rs2, imm      register indices and signed immediate
//   finish                 end-of-program level
//   mem_we/addr/wdata      instruction memory write port
//   busy, done, err        status (err is sticky)
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  cls,
  input  logic [2:0]  func3,
  input  logic        sub,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  input  logic        finish,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef PROGRAM_HALT_EN
  typedef enum logic [2:0] {IDLE, ENC, WRITE, HALT, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ENC, WRITE, DONE} state_t;
`endif

  state_t             state;
  logic [CW-1:0]      count;
  logic [31:0]        addr_next;

  // One-entry field buffer (data only, never reset)
  logic [2:0]         cls_p0;
  logic [2:0]         func3_p0;
  logic               sub_p0;
  logic [4:0]         rd_p0;
  logic [4:0]         rs1_p0;
  logic [4:0]         rs2_p0;
  logic signed [31:0] imm_p0;

  function automatic logic [31:0] encode(input logic [2:0] c, input logic [2:0] f3,
                                         input logic s, input logic [4:0] d,
                                         input logic [4:0] r1, input logic [4:0] r2,
                                         input logic signed [31:0] im);
    logic [31:0] w;
    w = '0;
    case (c)
      3'd0:    w = {im[11:0], r1, 3'b010, d, 7'b0000011};
      3'd1:    w = {im[11:5], r2, r1, 3'b010, im[4:0], 7'b0100011};
      3'd2:    w = {(s ? 7'b0100000 : 7'b0000000), r2, r1, f3, d, 7'b0110011};
      3'd3:    w = {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'b1100011};
      3'd4:    w = {im[11:0], r1, f3, d, 7'b0010011};
      3'd5:    w = {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
      3'd6:    w = {im[11:0], r1, 3'b000, d, 7'b1100111};
      default: w = {im[31:12], d, 7'b0110111};
    endcase
    return w;
  endfunction

  // 1 when the immediate fits the class's encodable range
  function automatic logic imm_ok(input logic [2:0] c, input logic signed [31:0] im);
    logic ok;
    ok = 1'b1;
    case (c)
      3'd0, 3'd1, 3'd4, 3'd6: ok = (im >= -32'sd2048) && (im <= 32'sd2047);
      3'd3:    ok = (im >= -32'sd4096) && (im <= 32'sd4094) && !im[0];
      3'd5:    ok = (im >= -32'sd1048576) && (im <= 32'sd1048574) && !im[0];
      3'd7:    ok = (im[11:0] == 12'h000);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  assign addr_next = BASE_ADDR + 32'({count, 2'b00});
  assign in_ready  = (state == IDLE) && (count < DEPTH_C);
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);

  // Stage p0: capture fields on accept
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      cls_p0   <= cls;
      func3_p0 <= func3;
      sub_p0   <= sub;
      rd_p0    <= rd;
      rs1_p0   <= rs1;
      rs2_p0   <= rs2;
      imm_p0   <= imm;
    end
  end

  // Control FSM; mem_* are registered so the strobe is glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      mem_we    <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (count == DEPTH_C) begin
            // memory full: give up on the rest of the program
            err   <= 1'b1;
            state <= DONE;
          end else if (in_valid) begin
            state <= ENC;
          end else if (finish) begin
`ifdef PROGRAM_HALT_EN
            mem_we    <= 1'b1;
            mem_wdata <= 32'h0000_0000;
            mem_addr  <= addr_next;
            state     <= HALT;
`else
            state <= DONE;
`endif
          end
        end
        // Stage p1: encode buffered fields into the output word
        ENC: begin
          mem_wdata <= encode(cls_p0, func3_p0, sub_p0, rd_p0, rs1_p0, rs2_p0, imm_p0);
          mem_addr  <= addr_next;
          mem_we    <= 1'b1;
          if (!imm_ok(cls_p0, imm_p0)) err <= 1'b1;
          state     <= WRITE;
        end
        // Stage p2: write strobe is high for this single cycle
        WRITE: begin
          mem_we <= 1'b0;
          count  <= count + CW'(1);
          state  <= IDLE;
        end
`ifdef PROGRAM_HALT_EN
        HALT: begin
          mem_we <= 1'b0;
          count  <= count + CW'(1);
          state  <= DONE;
        end
`endif
        DONE: begin
          mem_we <= 1'b0;
        end
        default: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
